alarm_annunciator: RTL and testbench
====================================

ALARM_ANNUNCIATOR -- requirements
Module: alarm_annunciator

Interface
REQ-001 SHALL have parameter SIREN_ON, default 4, siren-on cycles per pulse period.
REQ-002 SHALL have parameter SIREN_OFF, default 4, siren-off cycles per pulse period.
REQ-003 SHALL have parameter RESOUND, default 64, cycles in ACKED before a still-active alarm re-sounds.
REQ-004 SHALL have port CLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alarm_in  input  4  alarm sources, synchronous to CLOCK: bit0 ventilation, bit1 temperature, bit2 control room, bit3 reactor.
REQ-007 SHALL have port ack  input  1  operator acknowledge, level-sampled each cycle.
REQ-008 SHALL have port test  input  1  lamp test.
REQ-009 SHALL have port alarmeSonoro  output  1  registered siren drive, pulsed.
REQ-010 SHALL have port lamp  output  4  per-source indicator lamps.
REQ-011 SHALL have port first_out  output  4  source(s) that started the current alarm episode.
REQ-012 SHALL have port state  output  2  FSM state: 0 NORMAL, 1 ALERT, 2 ACKED.

Function
REQ-013 SHALL register alarm_in into prev each cycle; rise = alarm_in AND NOT prev.
REQ-014 SHALL set unacked[i] on rise[i]; SHALL clear all unacked bits on ack in ALERT, except bits rising that same cycle (rise wins).
REQ-015 NORMAL: any rise -> ALERT at that edge; first_out <= rise (multiple bits on simultaneous rises).
REQ-016 ALERT: ack with no rise -> ACKED if any alarm_in high, else NORMAL; otherwise stay.
REQ-017 ACKED: any rise -> ALERT; else all alarm_in low -> NORMAL; else resound counter at RESOUND-1 -> ALERT with unacked <= alarm_in; ack ignored.
REQ-018 Resound counter SHALL clear on every entry to ACKED and count only in ACKED.
REQ-019 Phase counter SHALL clear on every entry to ALERT, count 0..SIREN_ON+SIREN_OFF-1 then wrap; phase = (count < SIREN_ON).
REQ-020 alarmeSonoro SHALL equal phase while in ALERT, 0 otherwise; first siren-high cycle is the cycle right after the edge entering ALERT (1-cycle latency from sampled rise).
REQ-021 lamp[i] SHALL be 1 if test, else phase if unacked[i], else alarm_in[i] as sampled (steady); lamp[i] flashes with siren phase even in ACKED-resound.
REQ-022 first_out SHALL hold its value in ALERT/ACKED, ignore later rises, and clear on entry to NORMAL.
REQ-023 A source dropping while unacked SHALL keep flashing until ack (latched alarm).
REQ-024 test SHALL affect lamps only, never siren, state or latches.
REQ-025 Counters SHALL be sized by $clog2 of their parameter range; no overflow beyond wrap.

Reset
REQ-026 On reset: state NORMAL, alarmeSonoro 0, lamp 0, first_out 0, unacked 0, prev 0, both counters 0.
REQ-027 Reset SHALL override any simultaneous rise/ack; reset mid-ALERT returns to NORMAL next edge.
REQ-028 An alarm_in bit high at reset release SHALL register as a rise on the first post-reset edge.

Structure
REQ-029 Shared package SHALL hold state encoding, source bit indices (SRC_VENT, SRC_TEMP, SRC_SC, SRC_REA) and default parameter values.
REQ-030 Siren/flash phase counter SHALL be sub-module annunciator_phase_gen (inputs CLOCK, reset, clear, enable; output phase).

Verification (SIREN_ON=2, SIREN_OFF=2, RESOUND=10)
REQ-031 alarm_in 0000->0100 -> next cycle state=1, first_out=0100, alarmeSonoro 1,1,0,0,1..., lamp[2] same pattern.
REQ-032 ALERT on bit3, ack while bit3 high -> state=2, siren 0, lamp=1000 steady; bit3 low -> state=0, first_out=0000.
REQ-033 ACKED with bit1 held 10 cycles -> state=1, siren restarts high, lamp[1] flashing, first_out unchanged.
REQ-034 bits 0 and 3 rise same cycle -> first_out=1001; later bit1 rise leaves first_out=1001.
REQ-035 ack same cycle as bit2 rise in ALERT(bit0) -> unacked=0100, stays ALERT; pulse bit0 off before ack -> lamp[0] flashes until ack.
REQ-036 reset asserted mid-ALERT with test=1 -> all outputs 0 except lamp=1111; bit high through reset -> ALERT on first edge after release.

Source files
------------

// File: rtl/alarm_annunciator_pkg.sv
// Shared definitions for the alarm annunciator: state encoding, source bit
// positions, default timing parameters and a counter width helper.
package alarm_annunciator_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_ALERT  = 2'd1,
    ST_ACKED  = 2'd2
  } ann_state_e;

  localparam int NUM_SRC  = 4;
  localparam int SRC_VENT = 0;
  localparam int SRC_TEMP = 1;
  localparam int SRC_SC   = 2;
  localparam int SRC_REA  = 3;

  localparam int DEF_SIREN_ON  = 4;
  localparam int DEF_SIREN_OFF = 4;
  localparam int DEF_RESOUND   = 64;

  // A counter must always be at least one bit wide, even for a range of 1.
  function automatic int cnt_width(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/alarm_annunciator_phase_gen.sv
// Siren/flash phase generator: a wrapping counter whose phase is high for the
// first SIREN_ON counts of every SIREN_ON+SIREN_OFF period.
module annunciator_phase_gen
  import alarm_annunciator_pkg::*;
#(
  parameter int SIREN_ON  = DEF_SIREN_ON,
  parameter int SIREN_OFF = DEF_SIREN_OFF
) (
  input  logic CLOCK,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic phase
);

  localparam int PERIOD = SIREN_ON + SIREN_OFF;
  localparam int CW     = cnt_width(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count_q, count_d;

  // Clear wins over enable so every entry into ALERT restarts at phase 0.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign phase = (32'(count_q) < SIREN_ON);

endmodule

// File: rtl/alarm_annunciator.sv
// Four-source alarm annunciator: latches new alarms, pulses a siren and
// flashes lamps until acknowledged, and re-sounds alarms left standing too long.
module alarm_annunciator
  import alarm_annunciator_pkg::*;
#(
  parameter int SIREN_ON  = DEF_SIREN_ON,
  parameter int SIREN_OFF = DEF_SIREN_OFF,
  parameter int RESOUND   = DEF_RESOUND
) (
  input  logic                 CLOCK,
  input  logic                 reset,
  input  logic [NUM_SRC-1:0]   alarm_in,
  input  logic                 ack,
  input  logic                 test,
  output logic                 alarmeSonoro,
  output logic [NUM_SRC-1:0]   lamp,
  output logic [NUM_SRC-1:0]   first_out,
  output logic [1:0]           state
);

  localparam int RW = cnt_width(RESOUND);
  localparam logic [RW-1:0] RES_LAST = RW'(RESOUND - 1);

  ann_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] unacked_q, unacked_d;
  logic [NUM_SRC-1:0] first_out_q, first_out_d;
  logic [RW-1:0]      resound_q, resound_d;

  logic [NUM_SRC-1:0] rise;
  logic               any_rise;
  logic               any_active;
  logic               phase;
  logic               flash;
  logic               alert_entry;

  assign rise       = alarm_in & ~prev_q;
  assign any_rise   = |rise;
  assign any_active = |alarm_in;

  // Next-state logic; a new rise always takes priority over an acknowledge.
  always_comb begin
    state_d     = state_q;
    prev_d      = alarm_in;
    unacked_d   = unacked_q | rise;
    first_out_d = first_out_q;
    resound_d   = resound_q;

    case (state_q)
      ST_NORMAL: begin
        if (any_rise) begin
          state_d     = ST_ALERT;
          first_out_d = rise;
        end
      end
      ST_ALERT: begin
        if (ack) begin
          unacked_d = rise;
          if (!any_rise) begin
            state_d = any_active ? ST_ACKED : ST_NORMAL;
          end
        end
      end
      ST_ACKED: begin
        if (any_rise) begin
          state_d = ST_ALERT;
        end else if (!any_active) begin
          state_d = ST_NORMAL;
        end else if (resound_q == RES_LAST) begin
          state_d   = ST_ALERT;
          unacked_d = alarm_in;
        end
      end
      default: begin
        state_d = ST_NORMAL;
      end
    endcase

    if (state_d == ST_NORMAL) begin
      first_out_d = '0;
    end

    if (state_d == ST_ACKED) begin
      if (state_q != ST_ACKED) begin
        resound_d = '0;
      end else begin
        resound_d = (resound_q == RES_LAST) ? '0 : resound_q + RW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q     <= ST_NORMAL;
      prev_q      <= '0;
      unacked_q   <= '0;
      first_out_q <= '0;
      resound_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      unacked_q   <= unacked_d;
      first_out_q <= first_out_d;
      resound_q   <= resound_d;
    end
  end

  assign alert_entry = (state_d == ST_ALERT) && (state_q != ST_ALERT);

  annunciator_phase_gen #(
    .SIREN_ON  (SIREN_ON),
    .SIREN_OFF (SIREN_OFF)
  ) u_phase_gen (
    .CLOCK  (CLOCK),
    .reset  (reset),
    .clear  (alert_entry),
    .enable (state_d == ST_ALERT),
    .phase  (phase)
  );

  // Siren and flashing lamps are decoded purely from registered state.
  assign flash        = (state_q == ST_ALERT) && phase;
  assign alarmeSonoro = flash;
  assign lamp         = test ? '1
                             : ((unacked_q & {NUM_SRC{flash}}) | (~unacked_q & prev_q));
  assign first_out    = first_out_q;
  assign state        = state_q;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: directed scenarios plus random traffic, all
// checked against a behavioural model of the annunciator rules.
module tb_alarm_annunciator;

  localparam int ON      = 2;
  localparam int OFF     = 2;
  localparam int RES     = 10;
  localparam int PERIOD  = ON + OFF;

  logic       CLOCK = 1'b0;
  logic       reset;
  logic [3:0] alarm_in;
  logic       ack;
  logic       test;
  logic       alarmeSonoro;
  logic [3:0] lamp;
  logic [3:0] first_out;
  logic [1:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: 0 NORMAL, 1 ALERT, 2 ACKED; ages count edges since entering a state.
  int         m_state;
  logic [3:0] m_prev;
  logic [3:0] m_unack;
  logic [3:0] m_first;
  int         m_alert_age;
  int         m_acked_age;

  logic [3:0] cur_a;
  logic       cur_ack;
  logic       cur_test;
  logic       cur_rst;

  alarm_annunciator #(
    .SIREN_ON  (ON),
    .SIREN_OFF (OFF),
    .RESOUND   (RES)
  ) dut (
    .CLOCK        (CLOCK),
    .reset        (reset),
    .alarm_in     (alarm_in),
    .ack          (ack),
    .test         (test),
    .alarmeSonoro (alarmeSonoro),
    .lamp         (lamp),
    .first_out    (first_out),
    .state        (state)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic checkOutput(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic modelEdge(input logic [3:0] a, input logic k, input logic rst);
    logic [3:0] rise;
    int         ns;
    logic [3:0] nu;
    logic [3:0] nf;
    if (rst) begin
      m_state = 0; m_prev = '0; m_unack = '0; m_first = '0;
      m_alert_age = 0; m_acked_age = 0;
      return;
    end
    rise = a & ~m_prev;
    ns = m_state;
    nu = m_unack | rise;
    nf = m_first;
    if (m_state == 0) begin
      if (rise != 0) begin ns = 1; nf = rise; end
    end else if (m_state == 1) begin
      if (k) nu = rise;
      if (k && rise == 0) ns = (a != 0) ? 2 : 0;
    end else begin
      if (rise != 0) ns = 1;
      else if (a == 0) ns = 0;
      else if (m_acked_age == RES - 1) begin ns = 1; nu = a; end
    end
    if (ns == 0) nf = '0;
    if (ns == 1) m_alert_age = (m_state != 1) ? 0 : m_alert_age + 1;
    if (ns == 2) m_acked_age = (m_state != 2) ? 0 : m_acked_age + 1;
    m_state = ns; m_unack = nu; m_first = nf; m_prev = a;
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check at negedge.
  task automatic applyStimulus(input logic [3:0] a, input logic k, input logic t, input logic rst);
    logic       exp_siren;
    logic [3:0] exp_lamp;
    alarm_in = a; ack = k; test = t; reset = rst;
    @(posedge CLOCK);
    modelEdge(a, k, rst);
    @(negedge CLOCK);
    exp_siren = (m_state == 1) && ((m_alert_age % PERIOD) < ON);
    for (int i = 0; i < 4; i++) begin
      if (t) exp_lamp[i] = 1'b1;
      else if (m_unack[i]) exp_lamp[i] = exp_siren;
      else exp_lamp[i] = m_prev[i];
    end
    checkOutput("state", {2'b00, state}, 4'(m_state));
    checkOutput("siren", {3'b000, alarmeSonoro}, {3'b000, exp_siren});
    checkOutput("lamp", lamp, exp_lamp);
    checkOutput("first_out", first_out, m_first);
  endtask

  initial begin
    alarm_in = '0; ack = 1'b0; test = 1'b0; reset = 1'b1;
    m_state = 0; m_prev = '0; m_unack = '0; m_first = '0;
    m_alert_age = 0; m_acked_age = 0;

    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    checkOutput("reset_state", {2'b00, state}, 4'd0);
    checkOutput("reset_lamp", lamp, 4'b0000);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    // Control-room rise: siren and lamp[2] pulse 1,1,0,0,1.
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("rise_state", {2'b00, state}, 4'd1);
    checkOutput("rise_first", first_out, 4'b0100);
    checkOutput("pulse0", {3'b000, alarmeSonoro}, 4'd1);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("pulse1", {3'b000, alarmeSonoro}, 4'd1);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("pulse2", {3'b000, alarmeSonoro}, 4'd0);
    checkOutput("lamp_pulse2", lamp, 4'b0000);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("pulse3", {3'b000, alarmeSonoro}, 4'd0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("pulse4", {3'b000, alarmeSonoro}, 4'd1);
    checkOutput("lamp_pulse4", lamp, 4'b0100);

    // Acknowledge while active, then hold until the alarm re-sounds.
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    checkOutput("acked_state", {2'b00, state}, 4'd2);
    checkOutput("acked_lamp", lamp, 4'b0100);
    for (int i = 0; i < RES - 1; i++) applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    checkOutput("still_acked", {2'b00, state}, 4'd2);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    checkOutput("resound_state", {2'b00, state}, 4'd1);
    checkOutput("resound_siren", {3'b000, alarmeSonoro}, 4'd1);
    checkOutput("resound_first", first_out, 4'b0100);

    // Ack with nothing active returns to NORMAL.
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);
    checkOutput("back_normal", {2'b00, state}, 4'd0);
    checkOutput("normal_first", first_out, 4'b0000);

    // Simultaneous first-outs, later rise does not change them.
    applyStimulus(4'b1001, 1'b0, 1'b0, 1'b0);
    checkOutput("multi_first", first_out, 4'b1001);
    applyStimulus(4'b1011, 1'b0, 1'b0, 1'b0);
    checkOutput("later_first", first_out, 4'b1001);
    applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0);

    // Latched bit0 keeps flashing; ack with a same-cycle bit2 rise stays ALERT.
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0);
    checkOutput("ack_rise_state", {2'b00, state}, 4'd1);

    // Reset mid-ALERT under lamp test, with a source held through reset.
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b1000, 1'b0, 1'b1, 1'b1);
    checkOutput("rst_lamp", lamp, 4'b1111);
    checkOutput("rst_siren", {3'b000, alarmeSonoro}, 4'd0);
    checkOutput("rst_first", first_out, 4'b0000);
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    checkOutput("post_rst_state", {2'b00, state}, 4'd1);
    checkOutput("post_rst_first", first_out, 4'b1000);

    cur_a = 4'b1000;
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(7) == 0) cur_a[$urandom_range(3)] = ~cur_a[$urandom_range(3)];
      if ($urandom_range(11) == 0) cur_a = '0;
      cur_ack  = ($urandom_range(3) == 0);
      cur_test = ($urandom_range(7) == 0);
      cur_rst  = ($urandom_range(99) == 0);
      applyStimulus(cur_a, cur_ack, cur_test, cur_rst);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
